// File: rtl/fx_master.sv
// fx register bus initiator: host byte frames in, fx write/burst-read
// cycles out, read data and write acks back on the tx byte stream.
module fx_master #(
  parameter int          RD_LAT   = 1,
  parameter int          TIMEOUT  = 1000,
  parameter logic [7:0]  ACK_BYTE = 8'hAA
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [21:0] fx_waddr,
  output logic        fx_wr,
  output logic [7:0]  fx_data,
  output logic [21:0] fx_raddr,
  output logic        fx_rd,
  input  logic [7:0]  fx_q,
  output logic        busy,
  output logic [7:0]  err_cnt
);

  localparam int GW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE, GA2, GA1, GA0, GARG,
    WR, ACK, RISS, RWAIT
  } state_t;

  state_t      state;
  logic        op_wr;
  logic [5:0]  dev;
  logic [15:0] addr_lo;
  logic [8:0]  n;
  logic [8:0]  idx;
  logic [8:0]  idx_nx;
  logic [2:0]  lat;
  logic [GW-1:0] gap;
  logic [21:0] raddr_q;
  logic [21:0] cur_addr;
  logic [7:0]  err_inc;
  logic        in_frame;
  logic        rx_fire;
  logic        tx_free;
  logic        rd_go;

  assign in_frame = (state == GA2) || (state == GA1) ||
                    (state == GA0) || (state == GARG);
  assign rx_ready = !rst && ((state == IDLE) || in_frame);
  assign rx_fire  = rx_valid && rx_ready;
  assign tx_free  = !tx_valid || tx_ready;
  assign busy     = (state != IDLE);
  assign err_inc  = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
  assign idx_nx   = idx + 9'd1;
  assign cur_addr = {dev, addr_lo + {7'd0, idx}};

  // The read strobe fires in the issue cycle itself so a burst can
  // sustain one byte every two cycles; the address only moves then.
  assign rd_go    = !rst && (state == RISS) && tx_free;
  assign fx_rd    = rd_go;
  assign fx_raddr = rd_go ? cur_addr : raddr_q;

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state    <= IDLE;
      op_wr    <= 1'b0;
      dev      <= '0;
      addr_lo  <= '0;
      n        <= '0;
      idx      <= '0;
      lat      <= '0;
      gap      <= '0;
      raddr_q  <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      fx_waddr <= '0;
      fx_wr    <= 1'b0;
      fx_data  <= '0;
      err_cnt  <= '0;
    end else begin
      fx_wr <= 1'b0;
      if (tx_valid && tx_ready) tx_valid <= 1'b0;
      if (rd_go) raddr_q <= cur_addr;

      if (in_frame && !rx_fire) begin
        if (gap == GW'(TIMEOUT - 1)) begin
          state   <= IDLE;
          err_cnt <= err_inc;
        end else begin
          gap <= gap + 1'b1;
        end
      end else begin
        unique case (state)
          IDLE: begin
            if (rx_fire) begin
              if (rx_data == 8'h57 || rx_data == 8'h52) begin
                op_wr <= (rx_data == 8'h57);
                gap   <= '0;
                state <= GA2;
              end else begin
                err_cnt <= err_inc;
              end
            end
          end
          GA2: begin
            dev   <= rx_data[5:0];
            gap   <= '0;
            state <= GA1;
          end
          GA1: begin
            addr_lo[15:8] <= rx_data;
            gap   <= '0;
            state <= GA0;
          end
          GA0: begin
            addr_lo[7:0] <= rx_data;
            gap   <= '0;
            state <= GARG;
          end
          GARG: begin
            if (op_wr) begin
              fx_wr    <= 1'b1;
              fx_waddr <= {dev, addr_lo};
              fx_data  <= rx_data;
              state    <= WR;
            end else begin
              n     <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
              idx   <= '0;
              state <= RISS;
            end
          end
          WR: state <= ACK;
          ACK: begin
            if (tx_free) begin
              tx_data  <= ACK_BYTE;
              tx_valid <= 1'b1;
              state    <= IDLE;
            end
          end
          RISS: begin
            if (tx_free) begin
              lat   <= '0;
              state <= RWAIT;
            end
          end
          RWAIT: begin
            if (lat == 3'(RD_LAT - 1)) begin
              tx_data  <= fx_q;
              tx_valid <= 1'b1;
              idx      <= idx_nx;
              state    <= (idx_nx == n) ? IDLE : RISS;
            end else begin
              lat <= lat + 3'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fx_master.sv
// Directed bench for fx_master: writes, bursts, backpressure, wrap,
// bad opcode, frame timeout and reset during a long burst.
module tb_fx_master;

  localparam int TO = 1000;

  logic        clk_sys = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [21:0] fx_waddr;
  logic        fx_wr;
  logic [7:0]  fx_data;
  logic [21:0] fx_raddr;
  logic        fx_rd;
  logic [7:0]  fx_q = '0;
  logic        busy;
  logic [7:0]  err_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [21:0] rd_q[$];
  int          rd_cyc[$];
  logic [21:0] wa_q[$];
  logic [7:0]  wd_q[$];
  logic [7:0]  tx_q[$];

  fx_master dut (
    .clk_sys (clk_sys),
    .rst     (rst),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .fx_waddr(fx_waddr),
    .fx_wr   (fx_wr),
    .fx_data (fx_data),
    .fx_raddr(fx_raddr),
    .fx_rd   (fx_rd),
    .fx_q    (fx_q),
    .busy    (busy),
    .err_cnt (err_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic logic [7:0] slave_data(input logic [21:0] a);
    logic [7:0] d;
    case (a)
      22'h010010: d = 8'h11;
      22'h010011: d = 8'h22;
      22'h010012: d = 8'h33;
      default:    d = a[7:0] + 8'h01;
    endcase
    return d;
  endfunction

  // Slave with one cycle read latency; drives 0 when not selected
  always @(posedge clk_sys) begin
    fx_q <= fx_rd ? slave_data(fx_raddr) : 8'h00;
    cyc  <= cyc + 1;
    if (fx_rd) begin
      rd_q.push_back(fx_raddr);
      rd_cyc.push_back(cyc);
    end
    if (fx_wr) begin
      wa_q.push_back(fx_waddr);
      wd_q.push_back(fx_data);
    end
    if (tx_valid && tx_ready) tx_q.push_back(tx_data);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    rd_q.delete();
    rd_cyc.delete();
    wa_q.delete();
    wd_q.delete();
    tx_q.delete();
  endtask

  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    @(negedge clk_sys);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && t < 200) begin
      @(negedge clk_sys);
      t++;
    end
    if (t >= 200) chk("send_timeout", 1, 0);
    @(negedge clk_sys);
    rx_valid = 1'b0;
  endtask

  task automatic frame(input logic [7:0] op, input logic [7:0] a2,
                       input logic [7:0] a1, input logic [7:0] a0,
                       input logic [7:0] arg);
    send(op);
    send(a2);
    send(a1);
    send(a0);
    send(arg);
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while ((busy || tx_valid) && t < 3000) begin
      @(negedge clk_sys);
      t++;
    end
    chk(tag, (t >= 3000), 0);
    repeat (2) @(negedge clk_sys);
  endtask

  initial begin
    int t;
    int nrd;
    repeat (2) @(negedge clk_sys);
    chk("rst_busy", busy, 0);
    chk("rst_txv", tx_valid, 0);
    chk("rst_strobes", {fx_wr, fx_rd}, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_rxrdy", rx_ready, 0);
    chk("rst_addr", {fx_waddr, fx_raddr}, 0);
    rst = 1'b0;
    @(negedge clk_sys);
    chk("idle_rxrdy", rx_ready, 1);

    clr();
    frame(8'h57, 8'h01, 8'h00, 8'h20, 8'h05);
    wait_idle("wr_done");
    chk("wr_cnt", wa_q.size(), 1);
    chk("wr_addr", wa_q[0], 22'h010020);
    chk("wr_data", wd_q[0], 8'h05);
    chk("wr_nord", rd_q.size(), 0);
    chk("wr_txn", tx_q.size(), 1);
    chk("wr_ack", tx_q[0], 8'hAA);

    clr();
    frame(8'h52, 8'h01, 8'h00, 8'h10, 8'h03);
    wait_idle("rd_done");
    chk("rd_cnt", rd_q.size(), 3);
    chk("rd_a0", rd_q[0], 22'h010010);
    chk("rd_a1", rd_q[1], 22'h010011);
    chk("rd_a2", rd_q[2], 22'h010012);
    chk("rd_rate", rd_cyc[1] - rd_cyc[0], 2);
    chk("rd_txn", tx_q.size(), 3);
    chk("rd_d0", tx_q[0], 8'h11);
    chk("rd_d1", tx_q[1], 8'h22);
    chk("rd_d2", tx_q[2], 8'h33);
    chk("rd_busy", busy, 0);
    chk("rd_nowr", wa_q.size(), 0);

    clr();
    tx_ready = 1'b0;
    frame(8'h52, 8'h01, 8'h00, 8'h10, 8'h03);
    repeat (5) @(negedge clk_sys);
    chk("bp_hold5", {tx_valid, tx_data}, {1'b1, 8'h11});
    repeat (15) @(negedge clk_sys);
    chk("bp_rdcnt", rd_q.size(), 1);
    chk("bp_hold20", {tx_valid, tx_data}, {1'b1, 8'h11});
    chk("bp_busy", busy, 1);
    tx_ready = 1'b1;
    wait_idle("bp_done");
    chk("bp_rdcnt_end", rd_q.size(), 3);
    chk("bp_a2", rd_q[2], 22'h010012);
    chk("bp_txn", tx_q.size(), 3);
    chk("bp_d0", tx_q[0], 8'h11);
    chk("bp_d2", tx_q[2], 8'h33);

    clr();
    frame(8'h52, 8'h03, 8'hFF, 8'hFF, 8'h02);
    wait_idle("wrap_done");
    chk("wrap_cnt", rd_q.size(), 2);
    chk("wrap_a0", rd_q[0], 22'h03FFFF);
    chk("wrap_a1", rd_q[1], 22'h030000);
    chk("wrap_d0", tx_q[0], 8'h00);
    chk("wrap_d1", tx_q[1], 8'h01);

    clr();
    send(8'h41);
    @(negedge clk_sys);
    chk("badop_err", err_cnt, 1);
    chk("badop_busy", busy, 0);

    send(8'h57);
    send(8'h01);
    repeat (TO - 5) @(negedge clk_sys);
    chk("to_pending", busy, 1);
    chk("to_err_pre", err_cnt, 1);
    repeat (10) @(negedge clk_sys);
    chk("to_idle", busy, 0);
    chk("to_err", err_cnt, 2);
    chk("to_nowr", wa_q.size(), 0);

    clr();
    frame(8'h57, 8'h02, 8'h12, 8'h34, 8'h77);
    wait_idle("wr2_done");
    chk("wr2_addr", wa_q[0], 22'h021234);
    chk("wr2_data", wd_q[0], 8'h77);
    chk("wr2_ack", tx_q[0], 8'hAA);
    chk("wr2_err", err_cnt, 2);

    clr();
    frame(8'h52, 8'h00, 8'h00, 8'h00, 8'h00);
    t = 0;
    while (tx_q.size() < 10 && t < 2000) begin
      @(negedge clk_sys);
      t++;
    end
    chk("rr_reach10", (t >= 2000), 0);
    chk("rr_d9", tx_q[9], 8'h0A);
    rst = 1'b1;
    @(negedge clk_sys);
    chk("rr_busy", busy, 0);
    chk("rr_txv", tx_valid, 0);
    chk("rr_strobes", {fx_wr, fx_rd}, 0);
    chk("rr_err", err_cnt, 0);
    chk("rr_addr", {fx_waddr, fx_raddr, tx_data}, 0);
    nrd = rd_q.size();
    @(negedge clk_sys);
    rst = 1'b0;
    repeat (20) @(negedge clk_sys);
    chk("rr_nomore", rd_q.size(), nrd);
    chk("rr_busy2", busy, 0);

    clr();
    frame(8'h57, 8'h05, 8'h00, 8'h01, 8'hC3);
    wait_idle("wr3_done");
    chk("wr3_cnt", wa_q.size(), 1);
    chk("wr3_addr", wa_q[0], 22'h050001);
    chk("wr3_data", wd_q[0], 8'hC3);
    chk("wr3_ack", tx_q[0], 8'hAA);
    chk("wr3_nord", rd_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fx_master.md
Name: fx_master

Overview:
- Host-side initiator for the fx register bus.
- Parses framed command bytes from the host byte stream (FX2 link side) and issues single write cycles or auto-incrementing burst reads on fx_waddr/fx_wr/fx_data/fx_raddr/fx_rd.
- Returns read data and write acks on an outbound byte stream.
- One instance drives all fx slaves; slave fx_q outputs are OR-combined externally, since an unselected or idle slave drives 0.

Parameters:
RD_LAT, 1, cycles from the fx_rd pulse to the cycle fx_q is sampled (1..4)
TIMEOUT, 1000, max idle cycles between bytes of one frame before abort
ACK_BYTE, 8'hAA, response byte after a completed write

Ports:
clk_sys  in  1  system clock
rst  in  1  reset
rx_data  in  8  host command byte
rx_valid  in  1  rx_data valid
rx_ready  out  1  byte accepted when rx_valid&rx_ready
tx_data  out  8  response byte
tx_valid  out  1  tx_data valid; held until tx_ready
tx_ready  in  1  sink accepts byte
fx_waddr  out  22  write address {dev_id[5:0],reg[15:0]}
fx_wr  out  1  one-cycle write strobe
fx_data  out  8  write data
fx_raddr  out  22  read address
fx_rd  out  1  one-cycle read strobe
fx_q  in  8  OR of slave read data
busy  out  1  state != IDLE
err_cnt  out  8  saturating count of bad opcodes and timeouts

Interface: one clock; reset is synchronous and active-high.

Behaviour:
- Reset (rst=1 at clk_sys edge): state IDLE; all outputs 0; err_cnt=0; any pending tx byte is dropped.
- Frame format: OP, A2, A1, A0, ARG.
  - OP: 8'h57 = write, 8'h52 = read.
  - A2[5:0] is dev_id; A2[7:6] are ignored.
  - ARG: data for a write; count N for a read, where 0 means 256.
- rx_ready=1 only in IDLE, GA2, GA1, GA0, GARG; 0 in all other states.
- IDLE:
  - Accepted byte 57/52 → GA2.
  - Any other accepted byte → discard, err_cnt+1, stay IDLE.
- GA2 → GA1 → GA0 → GARG: advance one state per accepted byte.
- Timeout: in GA2..GARG, a gap counter resets on every accepted byte. When it reaches TIMEOUT → IDLE, err_cnt+1, partial frame discarded.
- Write path: GARG byte accepted → WR.
  - WR lasts one cycle: fx_wr=1, fx_waddr={A2[5:0],A1,A0}, fx_data=ARG.
  - Then → ACK.
  - ACK: when tx_valid=0, load tx_data=ACK_BYTE, set tx_valid=1, → IDLE.
- Read path: GARG byte accepted → RISS; base = {A2[5:0],A1,A0}; idx=0.
  - RISS: wait until tx_valid=0 (or tx_valid&tx_ready in the same cycle). Then pulse fx_rd for one cycle with fx_raddr = {dev, base[15:0]+idx} (16-bit wrap, dev field unchanged) → RWAIT.
  - RWAIT: count RD_LAT cycles after the fx_rd cycle. On the sampling cycle, tx_data=fx_q, tx_valid=1, idx+1.
  - Then → IDLE if idx==N, else → RISS.
  - With RD_LAT=1 and no backpressure: one byte every 2 cycles.
- tx handshake: tx_valid clears on the cycle tx_valid&tx_ready. tx_data is stable while tx_valid=1.
- fx_wr and fx_rd are never both 1; each strobe is exactly one cycle.
- fx_waddr and fx_raddr hold their last value between strobes.
- err_cnt saturates at 8'hFF.
- Reset mid-frame or mid-burst: immediate return to IDLE; no further strobes; the remaining burst is abandoned.
- rx bytes arriving while not ready are simply not accepted; the sender holds them.

Test Plan:
- Write: bytes 57,01,00,20,05 → one fx_wr pulse with fx_waddr=22'h010020, fx_data=05 → tx byte AA; no fx_rd.
- Burst read: bytes 52,01,00,10,03; slave model returns 11,22,33 one cycle after fx_rd → fx_raddr 010010, 010011, 010012 → tx 11,22,33 → busy=0.
- Backpressure: same read with tx_ready=0 for 20 cycles → only the first fx_rd is issued; tx_data=11 held stable; remaining strobes resume after acceptance.
- Wrap: read 52,03,FF,FF,02 → fx_raddr 03FFFF then 030000.
- Errors:
  - Byte 41 in IDLE → err_cnt=1.
  - Frame 57,01 then no byte for TIMEOUT cycles → IDLE, err_cnt=2, no fx_wr.
  - The next valid frame works normally.
- Reset: rst asserted during a 256-byte read after 10 bytes → outputs 0 next cycle, no further fx_rd; a subsequent write frame completes normally.
